check_key_driver: RTL and testbench
===================================

// Module: check_key_driver
// PURPOSE
//  Initiator for the ap_ctrl_hs handshake of the locked "check" core. Loads the
//  KEY_W-bit locking key from a 32-bit word stream into a holding register that
//  drives the core's locking_key input. Pulses ap_start per ap_ctrl_hs, waits for
//  ap_done, captures ap_return, and offers the result on a valid/ack port.
//  It sits between the key-provisioning/test host and the check core.
// PARAMETERS
//  KEY_W    12287  locking key width in bits
//  WORD_W   32     key stream word width
//  RET_W    32     core return width
//  TIMEOUT  4096   max cycles from start to done before abort; 0 = no timeout
//  NWORDS   ceil(KEY_W/WORD_W) = 384, derived localparam, not overridable
// PORTS
//  ap_clk         in   1       clock; all logic on the rising edge
//  ap_rst_n       in   1       asynchronous active-low reset
//  cmd_start      in   1       request one check run; sampled only in IDLE
//  cmd_reload     in   1       sampled with cmd_start: 1 = load a new key first
//  key_word_i     in   WORD_W  key stream data
//  key_valid_i    in   1       key stream valid
//  key_ready_o    out  1       key stream ready; high only in LOAD
//  locking_key_o  out  KEY_W   held key, to the core's locking_key input
//  core_start_o   out  1       to core ap_start
//  core_ready_i   in   1       from core ap_ready
//  core_done_i    in   1       from core ap_done
//  core_idle_i    in   1       from core ap_idle; status only
//  core_return_i  in   RET_W   from core ap_return; valid only with core_done_i
//  res_valid_o    out  1       result valid; held until res_ack_i
//  res_data_o     out  RET_W   captured ap_return; 0 on timeout
//  res_timeout_o  out  1       run aborted by timeout; qualified by res_valid_o
//  res_ack_i      in   1       result consumed
//  busy_o         out  1       high in every state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE. Word counter, timeout counter, locking_key_o, res_data_o = 0.
//    All 1-bit outputs = 0. Reset mid-run aborts at once; no result is produced.
//  States are IDLE, LOAD, START, WAIT, RESULT. Each transition takes one cycle.
//  IDLE: busy_o=0. cmd_start=1 and cmd_reload=1 -> LOAD, word counter cleared.
//    cmd_start=1 and cmd_reload=0 -> START; the previous key is reused, zeros after reset.
//  LOAD: key_ready_o=1. On valid&ready, word k goes to locking_key_o[k*WORD_W +: WORD_W].
//    Bits above KEY_W-1 are dropped; on the last word only bits [30:0] are used.
//    The counter increments per accepted word. Accepting word NWORDS-1 -> START.
//    Stalls on key_valid_i=0 are unlimited and do not count toward the timeout.
//  START: core_start_o=1, held until core_ready_i is sampled high.
//    Timeout counter runs from START entry.
//    ready=1 and done=1 in the same cycle: capture core_return_i -> RESULT.
//    ready=1 and done=0 -> WAIT; core_start_o drops on the next cycle.
//  WAIT: core_start_o=0. core_done_i=1 captures core_return_i -> RESULT.
//    core_done_i is a 1-cycle pulse and must not be missed.
//  Timeout (TIMEOUT>0): counter reaches TIMEOUT in START or WAIT -> RESULT with
//    res_timeout_o=1 and res_data_o=0. A done in the same cycle wins, with timeout=0.
//  RESULT: res_valid_o=1 and data stable until res_ack_i=1, then IDLE one cycle later.
//    ack and a new cmd_start in the same cycle: the cmd_start is ignored.
//  A late core_done_i after a timeout or in IDLE is ignored.
//  cmd_start outside IDLE is ignored; there is no queueing.
//  locking_key_o changes only in LOAD and is stable while core_start_o is high or in WAIT.
//  Latency: reload=0, core ready=done at cycle 0 -> res_valid_o 2 cycles after cmd_start.
// TESTING
//  Reload, 384 back-to-back words w_k=k; core returns 0x1 -> locking_key_o[63:32]=1,
//    bit 12286 = bit 30 of word 383, res_data_o=0x1.
//  Reload with key_valid_i toggled every other cycle -> the same key as back-to-back;
//    key_ready_o low outside LOAD.
//  cmd_reload=0, core ready=done same cycle with ap_return=0xDEADBEEF
//    -> res_valid_o 2 cycles after cmd_start, core_start_o high exactly 1 cycle.
//  TIMEOUT=16, core never done -> res_timeout_o=1 and res_data_o=0 at cycle 16;
//    a later done pulse is ignored.
//  ap_rst_n low during LOAD word 200 -> all outputs 0 asynchronously,
//    the next run starts clean, no spurious result.
//  res_ack_i held low 50 cycles -> res_data_o stable;
//    cmd_start during RESULT and on the ack cycle has no effect.

Source files
------------

// File: rtl/check_key_driver_if.sv
// Bundle of every signal between check_key_driver and its surroundings:
// command inputs, key word stream, ap_ctrl_hs core handshake and result port.
// The driver takes the master view; the host/core side takes the slave view.
interface check_key_driver_if #(
    parameter int KEY_W  = 12287,
    parameter int WORD_W = 32,
    parameter int RET_W  = 32
);
    logic              cmd_start;
    logic              cmd_reload;
    logic [WORD_W-1:0] key_word_i;
    logic              key_valid_i;
    logic              key_ready_o;
    logic [KEY_W-1:0]  locking_key_o;
    logic              core_start_o;
    logic              core_ready_i;
    logic              core_done_i;
    logic              core_idle_i;
    logic [RET_W-1:0]  core_return_i;
    logic              res_valid_o;
    logic [RET_W-1:0]  res_data_o;
    logic              res_timeout_o;
    logic              res_ack_i;
    logic              busy_o;

    modport master (
        input  cmd_start, cmd_reload,
        input  key_word_i, key_valid_i,
        output key_ready_o, locking_key_o,
        output core_start_o,
        input  core_ready_i, core_done_i, core_idle_i, core_return_i,
        output res_valid_o, res_data_o, res_timeout_o,
        input  res_ack_i,
        output busy_o
    );

    modport slave (
        output cmd_start, cmd_reload,
        output key_word_i, key_valid_i,
        input  key_ready_o, locking_key_o,
        input  core_start_o,
        output core_ready_i, core_done_i, core_idle_i, core_return_i,
        input  res_valid_o, res_data_o, res_timeout_o,
        output res_ack_i,
        input  busy_o
    );
endinterface

// File: rtl/check_key_driver.sv
// ap_ctrl_hs initiator for the locked "check" core. Optionally loads a new
// locking key from a word stream, starts the core, waits for done (with an
// optional watchdog) and presents the captured return value until acknowledged.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   S_IDLE   | waiting for cmd_start; busy_o low
//   S_LOAD   | accepting key words into the holding register (key_ready_o)
//   S_START  | core_start_o high until the core reports ap_ready
//   S_WAIT   | start accepted, waiting for the ap_done pulse
//   S_RESULT | res_valid_o high, result held until res_ack_i
module check_key_driver #(
    parameter int KEY_W   = 12287,
    parameter int WORD_W  = 32,
    parameter int RET_W   = 32,
    parameter int TIMEOUT = 4096
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst_n,
    check_key_driver_if.master     bus
);

    localparam int NWORDS  = (KEY_W + WORD_W - 1) / WORD_W;
    localparam int LAST_W  = KEY_W - (NWORDS - 1) * WORD_W;
    localparam int WCNT_W  = (NWORDS > 1) ? $clog2(NWORDS + 1) : 1;
    localparam int TMO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    // Watchdog is a down-counter loaded on START entry; terminal count 0 means
    // TIMEOUT cycles have elapsed since entry.
    localparam logic [TMO_W-1:0] TMO_LOAD = (TIMEOUT > 0) ? TMO_W'(TIMEOUT - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_RESULT
    } state_t;

    state_t              state_q, state_d;
    logic [WCNT_W-1:0]   wcnt_q;
    logic [TMO_W-1:0]    tmo_q;
    logic [KEY_W-1:0]    key_q;
    logic [RET_W-1:0]    res_data_q;
    logic                res_tmo_q;

    logic                key_fire;
    logic                last_word;
    logic                tmo_hit;
    logic                wcnt_clr;
    logic                tmo_load;
    logic                cap_ret;
    logic                cap_tmo;

    assign key_fire  = (state_q == S_LOAD) && bus.key_valid_i;
    assign last_word = (wcnt_q == WCNT_W'(NWORDS - 1));
    assign tmo_hit   = (TIMEOUT > 0) && (tmo_q == '0);

    // State register; reset aborts any run in progress.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and one-cycle control strobes for the datapath.
    always_comb begin
        state_d  = state_q;
        wcnt_clr = 1'b0;
        tmo_load = 1'b0;
        cap_ret  = 1'b0;
        cap_tmo  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_start) begin
                    if (bus.cmd_reload) begin
                        state_d  = S_LOAD;
                        wcnt_clr = 1'b1;
                    end else begin
                        state_d  = S_START;
                        tmo_load = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (key_fire && last_word) begin
                    state_d  = S_START;
                    tmo_load = 1'b1;
                end
            end
            S_START: begin
                // A done alongside ready beats a simultaneous watchdog expiry.
                if (bus.core_ready_i && bus.core_done_i) begin
                    state_d = S_RESULT;
                    cap_ret = 1'b1;
                end else if (tmo_hit) begin
                    state_d = S_RESULT;
                    cap_tmo = 1'b1;
                end else if (bus.core_ready_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.core_done_i) begin
                    state_d = S_RESULT;
                    cap_ret = 1'b1;
                end else if (tmo_hit) begin
                    state_d = S_RESULT;
                    cap_tmo = 1'b1;
                end
            end
            S_RESULT: begin
                if (bus.res_ack_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Key word counter: cleared on reload, advanced per accepted word.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            wcnt_q <= '0;
        end else if (wcnt_clr) begin
            wcnt_q <= '0;
        end else if (key_fire) begin
            wcnt_q <= wcnt_q + 1'b1;
        end
    end

    // Watchdog down-counter; only runs while the core owns the run, so key
    // stream stalls never count against it.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            tmo_q <= '0;
        end else if (tmo_load) begin
            tmo_q <= TMO_LOAD;
        end else if (((state_q == S_START) || (state_q == S_WAIT)) && (tmo_q != '0)) begin
            tmo_q <= tmo_q - 1'b1;
        end
    end

    // Key holding register: word k lands at bits [k*WORD_W +: WORD_W]; the last
    // word is truncated to the bits that fit below KEY_W.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            key_q <= '0;
        end else if (key_fire) begin
            for (int w = 0; w < NWORDS - 1; w++) begin
                if (wcnt_q == WCNT_W'(w)) begin
                    key_q[w*WORD_W +: WORD_W] <= bus.key_word_i;
                end
            end
            if (last_word) begin
                key_q[KEY_W-1 -: LAST_W] <= bus.key_word_i[LAST_W-1:0];
            end
        end
    end

    // Result capture: return value on done, zero plus flag on watchdog expiry.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            res_data_q <= '0;
            res_tmo_q  <= 1'b0;
        end else if (cap_ret) begin
            res_data_q <= bus.core_return_i;
            res_tmo_q  <= 1'b0;
        end else if (cap_tmo) begin
            res_data_q <= '0;
            res_tmo_q  <= 1'b1;
        end
    end

    assign bus.key_ready_o   = (state_q == S_LOAD);
    assign bus.core_start_o  = (state_q == S_START);
    assign bus.res_valid_o   = (state_q == S_RESULT);
    assign bus.busy_o        = (state_q != S_IDLE);
    assign bus.locking_key_o = key_q;
    assign bus.res_data_o    = res_data_q;
    assign bus.res_timeout_o = res_tmo_q;

endmodule

// File: tb/tb_check_key_driver.sv
// Directed bench for check_key_driver with a hand-driven core model.
module tb_check_key_driver;

    localparam int KEY_W  = 12287;
    localparam int WORD_W = 32;
    localparam int RET_W  = 32;
    localparam int NWORDS = 384;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    logic [KEY_W-1:0] exp_key;

    check_key_driver_if #(.KEY_W(KEY_W), .WORD_W(WORD_W), .RET_W(RET_W)) bus ();

    check_key_driver #(
        .KEY_W(KEY_W), .WORD_W(WORD_W), .RET_W(RET_W), .TIMEOUT(16)
    ) dut (
        .ap_clk   (clk),
        .ap_rst_n (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required finish before it");
        $fatal(1, "bench watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [KEY_W-1:0] build_key(input bit ones);
        logic [KEY_W-1:0] k_v;
        k_v = '0;
        for (int k = 0; k < NWORDS; k++) begin
            for (int b = 0; b < WORD_W; b++) begin
                if (k * WORD_W + b < KEY_W) begin
                    k_v[k*WORD_W + b] = ones ? 1'b1 : k[b];
                end
            end
        end
        return k_v;
    endfunction

    task automatic do_cmd(input logic reload);
        bus.cmd_start  = 1'b1;
        bus.cmd_reload = reload;
        tick();
        bus.cmd_start  = 1'b0;
        bus.cmd_reload = 1'b0;
    endtask

    task automatic feed_key(input bit toggle, input bit ones, input int nwords);
        int   k;
        int   cyc;
        logic rdy;
        k   = 0;
        cyc = 0;
        while (k < nwords && cyc < 4000) begin
            bus.key_word_i  = ones ? 32'hFFFF_FFFF : k[31:0];
            bus.key_valid_i = toggle ? ~cyc[0] : 1'b1;
            rdy = bus.key_ready_o;
            tick();
            if (bus.key_valid_i && rdy) k++;
            cyc++;
        end
        bus.key_valid_i = 1'b0;
        n_vec++;
        if (k !== nwords) begin
            n_err++;
            $display("FAIL feed_key: accepted %0d words, required %0d", k, nwords);
        end
    endtask

    task automatic do_ack();
        bus.res_ack_i = 1'b1;
        tick();
        bus.res_ack_i = 1'b0;
    endtask

    task automatic test_reset();
        n_vec++;
        if (bus.key_ready_o !== 1'b0 || bus.core_start_o !== 1'b0 || bus.res_valid_o !== 1'b0 ||
            bus.res_timeout_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags: got rdy=%b start=%b valid=%b tmo=%b busy=%b, required all 0",
                     bus.key_ready_o, bus.core_start_o, bus.res_valid_o, bus.res_timeout_o, bus.busy_o);
        end
        n_vec++;
        if (bus.locking_key_o !== '0 || bus.res_data_o !== '0) begin
            n_err++;
            $display("FAIL reset_data: key ones=%0d data=%h, required 0 and 0",
                     $countones(bus.locking_key_o), bus.res_data_o);
        end
    endtask

    task automatic test_reload_b2b();
        bus.core_ready_i = 1'b0;
        bus.core_done_i  = 1'b0;
        n_vec++;
        if (bus.key_ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_idle_ready: got %b, required 0", bus.key_ready_o);
        end
        do_cmd(1'b1);
        n_vec++;
        if (bus.key_ready_o !== 1'b1 || bus.busy_o !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_load: ready=%b busy=%b, required 1 1", bus.key_ready_o, bus.busy_o);
        end
        feed_key(1'b0, 1'b0, NWORDS);
        exp_key = build_key(1'b0);
        n_vec++;
        if (bus.core_start_o !== 1'b1 || bus.key_ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_start: start=%b ready=%b, required 1 0", bus.core_start_o, bus.key_ready_o);
        end
        n_vec++;
        if (bus.locking_key_o !== exp_key) begin
            n_err++;
            $display("FAIL b2b_key: got[95:0]=%h required[95:0]=%h differing bits=%0d",
                     bus.locking_key_o[95:0], exp_key[95:0], $countones(bus.locking_key_o ^ exp_key));
        end
        n_vec++;
        if (bus.locking_key_o[63:32] !== 32'h1 || bus.locking_key_o[12286] !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_key_slices: [63:32]=%h bit12286=%b, required 00000001 0",
                     bus.locking_key_o[63:32], bus.locking_key_o[12286]);
        end
        bus.core_ready_i  = 1'b1;
        bus.core_done_i   = 1'b1;
        bus.core_return_i = 32'h1;
        tick();
        bus.core_ready_i  = 1'b0;
        bus.core_done_i   = 1'b0;
        bus.core_return_i = '0;
        n_vec++;
        if (bus.res_valid_o !== 1'b1 || bus.res_data_o !== 32'h1 || bus.res_timeout_o !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_result: valid=%b data=%h tmo=%b, required 1 00000001 0",
                     bus.res_valid_o, bus.res_data_o, bus.res_timeout_o);
        end
        do_ack();
        n_vec++;
        if (bus.busy_o !== 1'b0 || bus.res_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_ack: busy=%b valid=%b, required 0 0", bus.busy_o, bus.res_valid_o);
        end
    endtask

    task automatic test_reload_toggle();
        do_cmd(1'b1);
        feed_key(1'b1, 1'b0, NWORDS);
        n_vec++;
        if (bus.locking_key_o !== build_key(1'b0)) begin
            n_err++;
            $display("FAIL toggle_key: got[95:0]=%h differing bits=%0d, required same key as back-to-back",
                     bus.locking_key_o[95:0], $countones(bus.locking_key_o ^ build_key(1'b0)));
        end
        bus.core_ready_i = 1'b1;
        tick();
        bus.core_ready_i = 1'b0;
        tick();
        n_vec++;
        if (bus.core_start_o !== 1'b0 || bus.busy_o !== 1'b1 || bus.key_ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL toggle_wait: start=%b busy=%b ready=%b, required 0 1 0",
                     bus.core_start_o, bus.busy_o, bus.key_ready_o);
        end
        bus.core_done_i   = 1'b1;
        bus.core_return_i = 32'h0000_0077;
        tick();
        bus.core_done_i   = 1'b0;
        bus.core_return_i = '0;
        n_vec++;
        if (bus.res_valid_o !== 1'b1 || bus.res_data_o !== 32'h77 || bus.key_ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL toggle_result: valid=%b data=%h ready=%b, required 1 00000077 0",
                     bus.res_valid_o, bus.res_data_o, bus.key_ready_o);
        end
        do_ack();
    endtask

    task automatic test_last_word();
        do_cmd(1'b1);
        feed_key(1'b0, 1'b1, NWORDS);
        exp_key = build_key(1'b1);
        n_vec++;
        if (bus.locking_key_o !== exp_key || bus.locking_key_o[12286] !== 1'b1) begin
            n_err++;
            $display("FAIL last_word_key: ones=%0d bit12286=%b, required ones=%0d bit12286=1",
                     $countones(bus.locking_key_o), bus.locking_key_o[12286], KEY_W);
        end
        bus.core_ready_i = 1'b1;
        bus.core_done_i  = 1'b1;
        tick();
        bus.core_ready_i = 1'b0;
        bus.core_done_i  = 1'b0;
        do_ack();
    endtask

    task automatic test_fast_run();
        bus.cmd_start     = 1'b1;
        bus.cmd_reload    = 1'b0;
        bus.core_ready_i  = 1'b1;
        bus.core_done_i   = 1'b1;
        bus.core_return_i = 32'hDEAD_BEEF;
        tick();
        bus.cmd_start = 1'b0;
        n_vec++;
        if (bus.core_start_o !== 1'b1 || bus.res_valid_o !== 1'b0 || bus.locking_key_o !== exp_key) begin
            n_err++;
            $display("FAIL fast_start: start=%b valid=%b key_diff=%0d, required 1 0 0",
                     bus.core_start_o, bus.res_valid_o, $countones(bus.locking_key_o ^ exp_key));
        end
        tick();
        bus.core_ready_i  = 1'b0;
        bus.core_done_i   = 1'b0;
        bus.core_return_i = '0;
        n_vec++;
        if (bus.res_valid_o !== 1'b1 || bus.res_data_o !== 32'hDEAD_BEEF ||
            bus.core_start_o !== 1'b0 || bus.res_timeout_o !== 1'b0) begin
            n_err++;
            $display("FAIL fast_result: valid=%b data=%h start=%b tmo=%b, required 1 deadbeef 0 0",
                     bus.res_valid_o, bus.res_data_o, bus.core_start_o, bus.res_timeout_o);
        end
        do_ack();
    endtask

    task automatic test_timeout();
        bus.core_ready_i = 1'b0;
        bus.core_done_i  = 1'b0;
        do_cmd(1'b0);
        for (int c = 1; c <= 16; c++) begin
            bus.core_ready_i = (c == 3);
            tick();
            n_vec++;
            if (bus.res_valid_o !== (c == 16) || (c < 16 && bus.core_start_o !== (c < 3))) begin
                n_err++;
                $display("FAIL timeout_cycle%0d: valid=%b start=%b, required valid=%b start=%b",
                         c, bus.res_valid_o, bus.core_start_o, (c == 16), (c < 3));
            end
        end
        bus.core_ready_i = 1'b0;
        n_vec++;
        if (bus.res_timeout_o !== 1'b1 || bus.res_data_o !== 32'h0) begin
            n_err++;
            $display("FAIL timeout_flag: tmo=%b data=%h, required 1 00000000",
                     bus.res_timeout_o, bus.res_data_o);
        end
        bus.core_done_i   = 1'b1;
        bus.core_return_i = 32'h0000_1234;
        tick();
        bus.core_done_i   = 1'b0;
        bus.core_return_i = '0;
        n_vec++;
        if (bus.res_valid_o !== 1'b1 || bus.res_timeout_o !== 1'b1 || bus.res_data_o !== 32'h0) begin
            n_err++;
            $display("FAIL timeout_late_done: valid=%b tmo=%b data=%h, required 1 1 00000000",
                     bus.res_valid_o, bus.res_timeout_o, bus.res_data_o);
        end
        do_ack();
        bus.core_done_i   = 1'b1;
        bus.core_return_i = 32'h0000_5678;
        tick();
        bus.core_done_i   = 1'b0;
        bus.core_return_i = '0;
        tick();
        n_vec++;
        if (bus.busy_o !== 1'b0 || bus.res_valid_o !== 1'b0 || bus.res_data_o !== 32'h0) begin
            n_err++;
            $display("FAIL idle_done: busy=%b valid=%b data=%h, required 0 0 00000000",
                     bus.busy_o, bus.res_valid_o, bus.res_data_o);
        end
    endtask

    task automatic test_done_vs_timeout();
        do_cmd(1'b0);
        bus.core_ready_i = 1'b1;
        tick();
        bus.core_ready_i = 1'b0;
        for (int j = 0; j < 14; j++) tick();
        n_vec++;
        if (bus.res_valid_o !== 1'b0 || bus.busy_o !== 1'b1) begin
            n_err++;
            $display("FAIL race_pre: valid=%b busy=%b, required 0 1", bus.res_valid_o, bus.busy_o);
        end
        bus.core_done_i   = 1'b1;
        bus.core_return_i = 32'hC0FF_EE00;
        tick();
        bus.core_done_i   = 1'b0;
        bus.core_return_i = '0;
        n_vec++;
        if (bus.res_valid_o !== 1'b1 || bus.res_timeout_o !== 1'b0 || bus.res_data_o !== 32'hC0FF_EE00) begin
            n_err++;
            $display("FAIL race_done_wins: valid=%b tmo=%b data=%h, required 1 0 c0ffee00",
                     bus.res_valid_o, bus.res_timeout_o, bus.res_data_o);
        end
        do_ack();
    endtask

    task automatic test_ack_hold();
        do_cmd(1'b0);
        bus.core_ready_i  = 1'b1;
        bus.core_done_i   = 1'b1;
        bus.core_return_i = 32'hA5A5_0F0F;
        tick();
        bus.core_ready_i  = 1'b0;
        bus.core_done_i   = 1'b0;
        for (int i = 0; i < 50; i++) begin
            bus.cmd_start     = (i % 3 == 0);
            bus.cmd_reload    = i[0];
            bus.core_done_i   = (i == 10);
            bus.core_return_i = i;
            tick();
            n_vec++;
            if (bus.res_valid_o !== 1'b1 || bus.res_data_o !== 32'hA5A5_0F0F || bus.busy_o !== 1'b1 ||
                bus.key_ready_o !== 1'b0 || bus.core_start_o !== 1'b0) begin
                n_err++;
                $display("FAIL hold_cycle%0d: valid=%b data=%h busy=%b rdy=%b start=%b, required 1 a5a50f0f 1 0 0",
                         i, bus.res_valid_o, bus.res_data_o, bus.busy_o, bus.key_ready_o, bus.core_start_o);
            end
        end
        bus.core_done_i   = 1'b0;
        bus.core_return_i = '0;
        bus.res_ack_i     = 1'b1;
        bus.cmd_start     = 1'b1;
        bus.cmd_reload    = 1'b1;
        tick();
        bus.res_ack_i  = 1'b0;
        bus.cmd_start  = 1'b0;
        bus.cmd_reload = 1'b0;
        n_vec++;
        if (bus.busy_o !== 1'b0 || bus.res_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL hold_ack: busy=%b valid=%b, required 0 0", bus.busy_o, bus.res_valid_o);
        end
        tick();
        n_vec++;
        if (bus.busy_o !== 1'b0 || bus.key_ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL hold_no_queue: busy=%b rdy=%b, required 0 0", bus.busy_o, bus.key_ready_o);
        end
    endtask

    task automatic test_reset_mid_load();
        do_cmd(1'b1);
        feed_key(1'b0, 1'b0, 200);
        bus.key_word_i  = 32'd200;
        bus.key_valid_i = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (bus.key_ready_o !== 1'b0 || bus.core_start_o !== 1'b0 || bus.res_valid_o !== 1'b0 ||
            bus.busy_o !== 1'b0 || bus.res_timeout_o !== 1'b0 || bus.locking_key_o !== '0 ||
            bus.res_data_o !== '0) begin
            n_err++;
            $display("FAIL mid_reset: rdy=%b start=%b valid=%b busy=%b tmo=%b key_ones=%0d data=%h, required all 0",
                     bus.key_ready_o, bus.core_start_o, bus.res_valid_o, bus.busy_o,
                     bus.res_timeout_o, $countones(bus.locking_key_o), bus.res_data_o);
        end
        bus.key_valid_i = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_key = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if (bus.res_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
                n_err++;
                $display("FAIL post_reset%0d: valid=%b busy=%b, required 0 0", i, bus.res_valid_o, bus.busy_o);
            end
        end
        do_cmd(1'b0);
        n_vec++;
        if (bus.core_start_o !== 1'b1 || bus.locking_key_o !== exp_key) begin
            n_err++;
            $display("FAIL clean_start: start=%b key_ones=%0d, required 1 0",
                     bus.core_start_o, $countones(bus.locking_key_o));
        end
        bus.core_ready_i  = 1'b1;
        bus.core_done_i   = 1'b1;
        bus.core_return_i = 32'h0000_0005;
        tick();
        bus.core_ready_i  = 1'b0;
        bus.core_done_i   = 1'b0;
        bus.core_return_i = '0;
        n_vec++;
        if (bus.res_valid_o !== 1'b1 || bus.res_data_o !== 32'h5 || bus.res_timeout_o !== 1'b0) begin
            n_err++;
            $display("FAIL clean_result: valid=%b data=%h tmo=%b, required 1 00000005 0",
                     bus.res_valid_o, bus.res_data_o, bus.res_timeout_o);
        end
        do_ack();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        exp_key = '0;
        rst_n             = 1'b0;
        bus.cmd_start     = 1'b0;
        bus.cmd_reload    = 1'b0;
        bus.key_word_i    = '0;
        bus.key_valid_i   = 1'b0;
        bus.core_ready_i  = 1'b0;
        bus.core_done_i   = 1'b0;
        bus.core_idle_i   = 1'b1;
        bus.core_return_i = '0;
        bus.res_ack_i     = 1'b0;
        tick();
        tick();
        test_reset();
        rst_n = 1'b1;
        tick();
        test_reload_b2b();
        test_reload_toggle();
        test_last_word();
        test_fast_run();
        test_timeout();
        test_done_vs_timeout();
        test_ack_hold();
        test_reset_mid_load();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
